// File: rtl/fetch_decode_reg.sv
// fetch_decode_reg
//   Pipeline register between instruction fetch and decode. Holds a main
//   entry that drives decode directly and a skid entry that absorbs one
//   extra instruction when decode stalls. A flush discards everything held
//   and anything accepted in the same cycle.
//
//   State | meaning
//   ------+---------------------------------------------
//   EMPTY | nothing held (main_v=0, skid_v=0)
//   ONE   | main entry valid, skid free (main_v=1, skid_v=0)
//   FULL  | main and skid both valid, in_ready=0
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous active-low reset
//   in_valid   in   fetch presents an instruction
//   in_ready   out  block can accept (registered state and reset only)
//   in_instr   in   instruction word
//   in_pc      in   PC of in_instr
//   in_pc4     in   PC+4 of in_instr (passed through unmodified)
//   flush      in   discard all held and incoming instructions
//   out_valid  out  decode-side entry valid
//   out_ready  in   decode accepts
//   out_instr  out  held instruction, NOP_INSTR when !out_valid
//   out_pc     out  held PC
//   out_pc4    out  held PC+4
//   stall_cnt  out  [IFID_STATS_EN only] saturating count of out_valid & !out_ready cycles
//   flush_cnt  out  [IFID_STATS_EN only] saturating count of flush cycles
//
// Optional feature macro: IFID_STATS_EN (adds stall_cnt / flush_cnt).

module fetch_decode_reg #(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  NOP_INSTR = 32'h00000013
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_pc4,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_pc4
`ifdef IFID_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occState_t;

    occState_t         state;

    logic [DATA_W-1:0] mainInstr;
    logic [DATA_W-1:0] mainPc;
    logic [DATA_W-1:0] mainPc4;
    logic [DATA_W-1:0] skidInstr;
    logic [DATA_W-1:0] skidPc;
    logic [DATA_W-1:0] skidPc4;

    logic              mainV;
    logic              skidV;
    logic              inFire;
    logic              outFire;

    assign mainV   = (state != EMPTY);
    assign skidV   = (state == FULL);

    // Ready only looks at registered occupancy and reset, so fetch never
    // sees a combinational path from decode's out_ready.
    assign in_ready = reset & ~skidV;
    assign inFire   = in_valid & in_ready;
    assign outFire  = mainV & out_ready;

    assign out_valid = mainV;
    assign out_instr = mainV ? mainInstr : NOP_INSTR;
    assign out_pc    = mainPc;
    assign out_pc4   = mainPc4;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= EMPTY;
            mainInstr <= '0;
            mainPc    <= '0;
            mainPc4   <= '0;
            skidInstr <= '0;
            skidPc    <= '0;
            skidPc4   <= '0;
`ifdef IFID_STATS_EN
            stall_cnt <= '0;
            flush_cnt <= '0;
`endif
        end else begin
            if (flush) begin
                // Incoming instruction (if any) is dropped; data regs hold.
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (inFire) begin
                            mainInstr <= in_instr;
                            mainPc    <= in_pc;
                            mainPc4   <= in_pc4;
                            state     <= ONE;
                        end
                    end
                    ONE: begin
                        if (inFire && outFire) begin
                            mainInstr <= in_instr;
                            mainPc    <= in_pc;
                            mainPc4   <= in_pc4;
                        end else if (inFire) begin
                            skidInstr <= in_instr;
                            skidPc    <= in_pc;
                            skidPc4   <= in_pc4;
                            state     <= FULL;
                        end else if (outFire) begin
                            state <= EMPTY;
                        end
                    end
                    FULL: begin
                        // in_ready is low here, so only a drain can happen.
                        if (outFire) begin
                            mainInstr <= skidInstr;
                            mainPc    <= skidPc;
                            mainPc4   <= skidPc4;
                            state     <= ONE;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
`ifdef IFID_STATS_EN
            if (mainV && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fetch_decode_reg.sv
module tb_fetch_decode_reg;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_pc4;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
`ifdef IFID_STATS_EN
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_decode_reg dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_pc4    (in_pc4),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_pc4   (out_pc4)
`ifdef IFID_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
        in_pc4   = pc + 32'd4;
    endtask

    task automatic checkOut(input string tag, input logic v, input logic [31:0] instr,
                            input logic [31:0] pc, input logic rdy);
        checkEq({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        checkEq({tag, ".instr"}, out_instr, instr);
        checkEq({tag, ".pc"},    out_pc, pc);
        checkEq({tag, ".pc4"},   out_pc4, pc + 32'd4);
        checkEq({tag, ".ready"}, {31'd0, in_ready}, {31'd0, rdy});
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        in_pc4    = 32'h0;
        tick();
        tick();
        // In reset: everything cleared, not ready.
        checkEq("rst.valid", {31'd0, out_valid}, 32'd0);
        checkEq("rst.instr", out_instr, NOP);
        checkEq("rst.pc",    out_pc, 32'h0);
        checkEq("rst.pc4",   out_pc4, 32'h0);
        checkEq("rst.ready", {31'd0, in_ready}, 32'd0);

        reset = 1'b1;
        tick();
        checkEq("idle.valid", {31'd0, out_valid}, 32'd0);
        checkEq("idle.instr", out_instr, NOP);
        checkEq("idle.ready", {31'd0, in_ready}, 32'd1);

        // Streaming with decode always ready: 1-cycle latency.
        out_ready = 1'b1;
        drive(1'b1, 32'h00A00093, 32'h0);
        tick();
        checkOut("stream0", 1'b1, 32'h00A00093, 32'h0, 1'b1);
        drive(1'b1, 32'h00100113, 32'h4);
        tick();
        checkOut("stream1", 1'b1, 32'h00100113, 32'h4, 1'b1);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        // Drained: NOP shown, PC regs keep last loaded value.
        checkOut("drain", 1'b0, NOP, 32'h4, 1'b1);

        // Stall fills skid; C refused while FULL.
        out_ready = 1'b0;
        drive(1'b1, 32'hAAAA0001, 32'h10);
        tick();
        checkOut("stallA", 1'b1, 32'hAAAA0001, 32'h10, 1'b1);
        drive(1'b1, 32'hBBBB0002, 32'h14);
        tick();
        checkOut("stallB", 1'b1, 32'hAAAA0001, 32'h10, 1'b0);
        drive(1'b1, 32'hCCCC0003, 32'h18);
        tick();
        checkOut("stallC", 1'b1, 32'hAAAA0001, 32'h10, 1'b0);
        out_ready = 1'b1;
        tick();
        checkOut("popB", 1'b1, 32'hBBBB0002, 32'h14, 1'b1);
        tick();
        checkOut("popC", 1'b1, 32'hCCCC0003, 32'h18, 1'b1);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        checkEq("popEnd.valid", {31'd0, out_valid}, 32'd0);

        // Flush while FULL, decode consuming and D offered in the same cycle.
        out_ready = 1'b0;
        drive(1'b1, 32'hEEEE0005, 32'h20);
        tick();
        drive(1'b1, 32'hFFFF0006, 32'h24);
        tick();
        checkOut("fullEF", 1'b1, 32'hEEEE0005, 32'h20, 1'b0);
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'hDDDD0004, 32'h28);
        tick();
        checkOut("flushFull", 1'b0, NOP, 32'h20, 1'b1);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        checkEq("flushFull.noD", {31'd0, out_valid}, 32'd0);

        // Flush in ONE with a real in_fire of H: H discarded.
        out_ready = 1'b0;
        drive(1'b1, 32'h99990007, 32'h30);
        tick();
        checkOut("oneG", 1'b1, 32'h99990007, 32'h30, 1'b1);
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h88880008, 32'h34);
        tick();
        checkOut("flushOne", 1'b0, NOP, 32'h30, 1'b1);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        checkEq("flushOne.noH", {31'd0, out_valid}, 32'd0);

`ifdef IFID_STATS_EN
        // Stalls at edges accepting B, offering C, accepting F; flushes twice.
        checkEq("stats.stall", stall_cnt, 32'd3);
        checkEq("stats.flush", {16'd0, flush_cnt}, 32'd2);
`endif

        // Reset while FULL.
        out_ready = 1'b0;
        drive(1'b1, 32'h12340009, 32'h40);
        tick();
        drive(1'b1, 32'h5678000A, 32'h44);
        tick();
        checkOut("preRst", 1'b1, 32'h12340009, 32'h40, 1'b0);
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        checkEq("midRst.valid", {31'd0, out_valid}, 32'd0);
        checkEq("midRst.instr", out_instr, NOP);
        checkEq("midRst.pc",    out_pc, 32'h0);
        checkEq("midRst.pc4",   out_pc4, 32'h0);
        checkEq("midRst.ready", {31'd0, in_ready}, 32'd0);
`ifdef IFID_STATS_EN
        checkEq("midRst.stall", stall_cnt, 32'd0);
        checkEq("midRst.flush", {16'd0, flush_cnt}, 32'd0);
`endif
        reset = 1'b1;
        tick();
        checkEq("postRst.ready", {31'd0, in_ready}, 32'd1);
        checkEq("postRst.valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        drive(1'b1, 32'hCAFE000B, 32'h50);
        tick();
        checkOut("postRstK", 1'b1, 32'hCAFE000B, 32'h50, 1'b1);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        checkEq("postRstK.drain", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
